// File: rtl/imem_loader.sv
// Boot-time loader: turns a length-prefixed byte stream into 32-bit
// instruction-memory word writes while holding the core stalled.
module imem_loader #(
    parameter int          MEM_BYTES = 512,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_stall,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        FIN
    } state_t;

    localparam logic [31:0] WORDS = 32'(MEM_BYTES / 4);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] len_q;
    logic [15:0] word_idx_q;
    logic [15:0] word_nxt;
    logic [1:0]  byte_idx_q;
    logic [23:0] asm_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic        done_q;
    logic        err_q;
    logic [15:0] words_q;
    logic        in_cap;
    logic        xfer;

    assign word_nxt = word_idx_q + 16'd1;
    assign in_cap   = {16'd0, word_idx_q} < WORDS;
    assign xfer     = rx_valid && rx_ready;

    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rx_ready  = 1'b0;
        cpu_stall = 1'b0;
        wr_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LEN0;
                end
            end
            LEN0: begin
                rx_ready  = 1'b1;
                cpu_stall = 1'b1;
                if (rx_valid) begin
                    state_d = LEN1;
                end
            end
            LEN1: begin
                rx_ready  = 1'b1;
                cpu_stall = 1'b1;
                if (rx_valid) begin
                    if ({rx_data, len_q[7:0]} == 16'd0) begin
                        state_d = FIN;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                rx_ready  = 1'b1;
                cpu_stall = 1'b1;
                if (rx_valid && byte_idx_q == 2'd3) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cpu_stall = 1'b1;
                wr_en     = in_cap;
                if (word_nxt == len_q) begin
                    state_d = FIN;
                end else begin
                    state_d = DATA;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Out-of-capacity words are still framed and assembled, only the strobe is withheld.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        words_q    <= '0;
                        word_idx_q <= '0;
                        byte_idx_q <= '0;
                    end
                end
                LEN0: begin
                    if (xfer) begin
                        len_q[7:0] <= rx_data;
                    end
                end
                LEN1: begin
                    if (xfer) begin
                        len_q[15:8] <= rx_data;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        unique case (byte_idx_q)
                            2'd0: asm_q[7:0]   <= rx_data;
                            2'd1: asm_q[15:8]  <= rx_data;
                            2'd2: asm_q[23:16] <= rx_data;
                            2'd3: begin
                                wr_data_q <= {rx_data, asm_q};
                                wr_addr_q <= BASE_ADDR +
                                             {14'd0, word_idx_q, 2'b00};
                            end
                            default: ;
                        endcase
                    end
                end
                WRITE: begin
                    word_idx_q <= word_nxt;
                    if (in_cap) begin
                        words_q <= words_q + 16'd1;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                FIN: begin
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (full and 2-word capacity)
// share one stimulus stream and are checked against a write-list model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        rdy_a, wen_a, stall_a, done_a, err_a;
    logic [31:0] waddr_a, wdata_a;
    logic [15:0] wl_a;
    logic        rdy_b, wen_b, stall_b, done_b, err_b;
    logic [31:0] waddr_b, wdata_b;
    logic [15:0] wl_b;

    imem_loader dut_a (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rdy_a),
        .wr_en(wen_a), .wr_addr(waddr_a), .wr_data(wdata_a),
        .cpu_stall(stall_a), .done(done_a), .err(err_a),
        .words_loaded(wl_a)
    );

    imem_loader #(.MEM_BYTES(8)) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rdy_b),
        .wr_en(wen_b), .wr_addr(waddr_b), .wr_data(wdata_b),
        .cpu_stall(stall_b), .done(done_b), .err(err_b),
        .words_loaded(wl_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int xfers = 0;
    int wr_cnt_a = 0;
    int wr_cnt_b = 0;
    int first_wr = -1;
    int done_cyc = 0;
    logic [63:0] last_a, last_b, ea, eb;
    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];
    logic [7:0]  bq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every strobe must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (wen_a === 1'b1) begin
            wr_cnt_a++;
            last_a = {waddr_a, wdata_a};
            if (wr_cnt_a == 1) first_wr = cyc - t0;
            if (exp_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_a_unexpected: got %0h", last_a);
            end else begin
                ea = exp_a.pop_front();
                chk("wr_a_addr", {32'd0, waddr_a}, {32'd0, ea[63:32]});
                chk("wr_a_data", {32'd0, wdata_a}, {32'd0, ea[31:0]});
            end
        end
        if (wen_b === 1'b1) begin
            wr_cnt_b++;
            last_b = {waddr_b, wdata_b};
            if (exp_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_b_unexpected: got %0h", last_b);
            end else begin
                eb = exp_b.pop_front();
                chk("wr_b_addr", {32'd0, waddr_b}, {32'd0, eb[63:32]});
                chk("wr_b_data", {32'd0, wdata_b}, {32'd0, eb[31:0]});
            end
        end
        if (reset === 1'b0) begin
            chk("rdy_same", {63'd0, rdy_b}, {63'd0, rdy_a});
            if (rdy_a === 1'b1) chk("rdy_stall", {63'd0, stall_a}, 64'd1);
        end
    end

    task automatic send(input logic [7:0] b, input bit pulse);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        if (pulse) start = 1'b1;
        while (1) begin
            @(negedge clk);
            if (rdy_a === 1'b1) break;
            n++;
            if (n > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: byte %0h not accepted", b);
                break;
            end
        end
        @(posedge clk);
        #1;
        xfers++;
        start    = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic begin_load();
        start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_load(input bit gap, input int pulse_at);
        int len;
        int ok = 0;
        logic [31:0] w;
        len = {bq[1], bq[0]};
        for (int k = 0; k < len; k++) begin
            w = {bq[2+4*k+3], bq[2+4*k+2], bq[2+4*k+1], bq[2+4*k]};
            if (k < 128) exp_a.push_back({32'(4 * k), w});
            if (k < 2)   exp_b.push_back({32'(4 * k), w});
        end
        wr_cnt_a = 0;
        wr_cnt_b = 0;
        first_wr = -1;
        xfers = 0;
        begin_load();
        for (int i = 0; i < bq.size(); i++) begin
            if (gap && i > 0) begin
                rx_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send(bq[i], i == pulse_at);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                ok = 1;
                break;
            end
        end
        done_cyc = cyc - t0;
        chk("done_seen", 64'(ok), 64'd1);
        if (!gap) chk("done_cycle", 64'(done_cyc), 64'(4 + 5 * len));
        chk("done_b", {63'd0, done_b}, 64'd1);
        chk("stall_idle", {63'd0, stall_a}, 64'd0);
        chk("wl_a", {48'd0, wl_a}, 64'(len < 128 ? len : 128));
        chk("err_a", {63'd0, err_a}, 64'(len > 128));
        chk("wl_b", {48'd0, wl_b}, 64'(len < 2 ? len : 2));
        chk("err_b", {63'd0, err_b}, 64'(len > 2));
        chk("pending_a", 64'(exp_a.size()), 64'd0);
        chk("pending_b", 64'(exp_b.size()), 64'd0);
        chk("consumed", 64'(xfers), 64'(bq.size()));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'hAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", {63'd0, rdy_a}, 64'd0);
        chk("rst_wen", {63'd0, wen_a}, 64'd0);
        chk("rst_addr", {32'd0, waddr_a}, 64'd0);
        chk("rst_data", {32'd0, wdata_a}, 64'd0);
        chk("rst_stall", {63'd0, stall_a}, 64'd0);
        chk("rst_flags", {61'd0, done_a, err_a, 1'b0}, 64'd0);
        chk("rst_wl", {48'd0, wl_a}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("idle_rdy", {63'd0, rdy_a}, 64'd0);
        chk("idle_stall", {63'd0, stall_a}, 64'd0);
        @(posedge clk);
        #1;

        bq = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        run_load(1'b0, -1);
        chk("single_wr_cycle", 64'(first_wr), 64'd7);
        chk("single_done_cycle", 64'(done_cyc), 64'd9);
        chk("single_last", last_a, 64'h00000000_00000013);
        chk("single_count", 64'(wr_cnt_a), 64'd1);

        bq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'hA0, 8'h00};
        run_load(1'b1, -1);
        chk("bp_count", 64'(wr_cnt_a), 64'd2);
        chk("bp_last", last_a, 64'h00000004_00A00113);

        bq = '{8'h00, 8'h00};
        run_load(1'b0, -1);
        chk("zero_count", 64'(wr_cnt_a), 64'd0);
        chk("zero_done_cycle", 64'(done_cyc), 64'd4);

        bq = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(1'b0, 1);
        chk("ign_done_cycle", 64'(done_cyc), 64'd9);
        chk("ign_last", last_a, 64'h00000000_DEADBEEF);

        bq = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        run_load(1'b0, -1);
        chk("ovf_count_b", 64'(wr_cnt_b), 64'd2);
        chk("ovf_last_b", last_b, 64'h00000004_88776655);
        chk("ovf_last_a", last_a, 64'h00000008_CCBBAA99);
        chk("ovf_err_b", {63'd0, err_b}, 64'd1);
        chk("ovf_done_cycle", 64'(done_cyc), 64'd19);

        wr_cnt_a = 0;
        wr_cnt_b = 0;
        begin_load();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'h13, 1'b0);
        send(8'h00, 1'b0);
        reset = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("mid_stall", {63'd0, stall_a}, 64'd0);
        chk("mid_done", {63'd0, done_a}, 64'd0);
        chk("mid_err", {63'd0, err_a}, 64'd0);
        chk("mid_rdy", {63'd0, rdy_a}, 64'd0);
        repeat (10) @(negedge clk);
        chk("mid_no_write", 64'(wr_cnt_a), 64'd0);
        @(posedge clk);
        #1;

        bq = '{8'h02, 8'h00, 8'h37, 8'h01, 8'h00, 8'h80,
               8'h6F, 8'h00, 8'h00, 8'h00};
        run_load(1'b0, -1);
        chk("after_rst_count", 64'(wr_cnt_a), 64'd2);
        chk("after_rst_last", last_a, 64'h00000004_0000006F);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the byte-addressed, little-endian instruction memory of the pipelined RISC-V core. It accepts a length-prefixed byte stream over a valid/ready handshake and assembles 32-bit instructions, then issues one word write per instruction at consecutive word addresses. While a load is in progress it holds the core stalled. It sits between the host/debug byte source and the instruction memory write port; the fetch stage remains the reader of the same memory.

## Interface
- MEM_BYTES, 512, instruction memory capacity in bytes; word capacity = MEM_BYTES/4.
- BASE_ADDR, 32'h0, byte address of the first written word; must be 4-aligned.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load when idle, ignored otherwise.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts byte; a transfer occurs when rx_valid && rx_ready.
- wr_en  out  1  one-cycle word write strobe to instruction memory.
- wr_addr  out  32  byte address of the word; bytes wr_addr..wr_addr+3 are written.
- wr_data  out  32  word data; wr_data[7:0] goes to wr_addr, wr_data[31:24] to wr_addr+3.
- cpu_stall  out  1  high while a load is in progress.
- done  out  1  sticky: last load completed; cleared by start or reset.
- err  out  1  sticky: stream length exceeded capacity; cleared by start or reset.
- words_loaded  out  16  count of words actually written in the current or last load.

## Operation
- Stream format: LEN[7:0], LEN[15:8], then LEN words of 4 bytes each, least-significant byte first.
- FSM states: IDLE, LEN0, LEN1, DATA, WRITE, FIN.
- IDLE: rx_ready=0, cpu_stall=0. On start: clear done, err, and words_loaded; clear word_idx and byte_idx; go to LEN0.
- LEN0: rx_ready=1. On a transfer, capture len[7:0] and go to LEN1.
- LEN1: rx_ready=1. On a transfer, capture len[15:8]. If the full 16-bit len == 0, go to FIN; otherwise go to DATA.
- DATA: rx_ready=1. On a transfer, place the byte into assembly bits [8*byte_idx+7 : 8*byte_idx] and increment byte_idx (2 bits). On the transfer with byte_idx==3, go to WRITE.
- WRITE: rx_ready=0.
  - wr_addr = BASE_ADDR + 4*word_idx and wr_data = the assembled word.
  - If word_idx < MEM_BYTES/4: wr_en=1 and words_loaded increments. Otherwise wr_en=0 and err is set.
  - word_idx increments. If the new word_idx == len, go to FIN; otherwise go to DATA.
- FIN: cpu_stall=0, rx_ready=0. Set done and go to IDLE.
- Overflow handling: bytes beyond capacity are still consumed so the stream stays framed. No write ever occurs outside capacity.
- Outputs in states other than those listed: wr_en=0. wr_addr and wr_data hold their last values.
- cpu_stall is high in LEN0, LEN1, DATA, and WRITE.
- Arithmetic: word_idx is 16 bits and wr_addr is computed modulo 2^32. A len of 16'hFFFF is legal.

## Timing
- Reset values: all outputs are 0 and state is IDLE. Any partially loaded memory contents are left as written.
- Reset mid-load: the next cycle is IDLE with cpu_stall=0, done=0, and err=0. No further writes occur.
- Reset has priority over start and over any transfer in the same cycle.
- Cycle budget with start at cycle 0 and rx_valid held high:
  - Length bytes transfer in cycles 1 and 2.
  - Word k (from 0) transfers bytes in cycles 3+5k through 6+5k, and its wr_en pulse is in cycle 7+5k.
  - FIN is in cycle 3+5N; done reads 1 from cycle 4+5N.
- Write latency: wr_en is asserted exactly one cycle after the 4th byte's transfer.
- Backpressure: rx_valid may drop in any cycle; the FSM holds state and no byte is captured without a transfer.
- rx_ready does not depend combinationally on rx_valid.
- A start pulse in any state other than IDLE has no effect.

## Test plan
- Reset: hold reset for 3 cycles with rx_valid=1 and start=1 → all outputs 0 and rx_ready=0. Release → IDLE.
- Single word: start, then bytes 01 00 13 00 00 00 back-to-back.
  - Expect one wr_en pulse in cycle 7 with wr_addr=0x0 and wr_data=0x00000013.
  - Expect done=1 from cycle 9 and words_loaded=1.
- Two words with backpressure: bytes 02 00 93 00 50 00 13 01 A0 00, with rx_valid low every other cycle.
  - Expect writes 0x00500093@0x0 and 0x00A00113@0x4, and exactly 2 wr_en pulses.
- Zero length and start ignored: bytes 00 00 → FIN with no wr_en and done=1. A start pulse in LEN1 during a separate load → no effect on the FSM.
- Overflow: MEM_BYTES=8 with len=3 → writes at 0x0 and 0x4 only, err=1, words_loaded=2, done=1. All 14 bytes are consumed.
- Reset mid-load: assert reset after the 2nd data byte of word 0 → no wr_en, and cpu_stall=0 on the next cycle. A following clean load still writes correctly.
